// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: passes ALU results through to the writeback
// register, or runs a multi-cycle access on an external asynchronous SRAM
// while stalling the upstream pipeline. All SRAM strobes are decoded from
// the state register alone so no input can glitch them.
module mem_stage_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 18,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [DATA_W-1:0] res,
   input  logic              flag,
   input  logic              memwr_ctrl,
   input  logic              memrd_ctrl,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              stall,
   output logic [DATA_W-1:0] res_out,
   output logic              flag_out,
   output logic              out_valid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_out,
   output logic              ram_data_oe,
   input  logic [DATA_W-1:0] ram_data_in,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
);

   // Counter only needs to reach WAIT_CYC-1; wide enough for WAIT_CYC itself.
   localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RD     = 2'd1;
   localparam logic [1:0] WR     = 2'd2;
   localparam logic [1:0] WR_REC = 2'd3;

   logic [1:0]        state_reg,     state_next;
   logic [CNT_W-1:0]  counter_reg,   counter_next;
   logic [DATA_W-1:0] res_out_reg,   res_out_next;
   logic              flag_out_reg,  flag_out_next;
   logic              out_valid_reg, out_valid_next;
   logic [ADDR_W-1:0] ram_addr_reg,  ram_addr_next;
   logic [DATA_W-1:0] wdata_reg,     wdata_next;
   logic              stall_comb;

   // Next-state / datapath decode; memory requests are only looked at in IDLE.
   always_comb begin
      state_next     = state_reg;
      counter_next   = counter_reg;
      res_out_next   = res_out_reg;
      flag_out_next  = flag_out_reg;
      out_valid_next = out_valid_reg;
      ram_addr_next  = ram_addr_reg;
      wdata_next     = wdata_reg;
      stall_comb     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (valid && memwr_ctrl) begin
               // Write wins when both controls are raised.
               stall_comb     = 1'b1;
               ram_addr_next  = mem_addr;
               wdata_next     = wr_data;
               counter_next   = '0;
               out_valid_next = 1'b0;
               state_next     = WR;
            end else if (valid && memrd_ctrl) begin
               stall_comb     = 1'b1;
               ram_addr_next  = mem_addr;
               counter_next   = '0;
               out_valid_next = 1'b0;
               state_next     = RD;
            end else if (valid) begin
               res_out_next   = res;
               flag_out_next  = flag;
               out_valid_next = 1'b1;
            end else begin
               out_valid_next = 1'b0;
            end
         end

         RD: begin
            if (counter_reg == CNT_LAST) begin
               // Completion cycle: release upstream so it advances at this edge.
               res_out_next   = ram_data_in;
               flag_out_next  = flag;
               out_valid_next = 1'b1;
               counter_next   = '0;
               state_next     = IDLE;
            end else begin
               stall_comb     = 1'b1;
               out_valid_next = 1'b0;
               counter_next   = counter_reg + 1'b1;
            end
         end

         WR: begin
            stall_comb     = 1'b1;
            out_valid_next = 1'b0;
            if (counter_reg == CNT_LAST) begin
               counter_next = '0;
               state_next   = WR_REC;
            end else begin
               counter_next = counter_reg + 1'b1;
            end
         end

         WR_REC: begin
            // Data bus still driven here so hold time after we_n rises is met.
            res_out_next   = res;
            flag_out_next  = flag;
            out_valid_next = 1'b1;
            counter_next   = '0;
            state_next     = IDLE;
         end

         default: begin
            counter_next   = '0;
            out_valid_next = 1'b0;
            state_next     = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         counter_reg   <= '0;
         res_out_reg   <= '0;
         flag_out_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         ram_addr_reg  <= '0;
         wdata_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         counter_reg   <= counter_next;
         res_out_reg   <= res_out_next;
         flag_out_reg  <= flag_out_next;
         out_valid_reg <= out_valid_next;
         ram_addr_reg  <= ram_addr_next;
         wdata_reg     <= wdata_next;
      end
   end

   // Strobes come from the state register only; oe_n and data_oe are
   // mutually exclusive by construction.
   assign ram_ce_n     = (state_reg == IDLE);
   assign ram_oe_n     = (state_reg != RD);
   assign ram_we_n     = (state_reg != WR);
   assign ram_data_oe  = (state_reg == WR) || (state_reg == WR_REC);

   assign stall        = stall_comb;
   assign res_out      = res_out_reg;
   assign flag_out     = flag_out_reg;
   assign out_valid    = out_valid_reg;
   assign ram_addr     = ram_addr_reg;
   assign ram_data_out = wdata_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl (DATA_W=16, ADDR_W=18, WAIT_CYC=2).
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_mem_stage_ctrl;

   logic        clk;
   logic        rst;
   logic        valid;
   logic [15:0] res;
   logic        flag;
   logic        memwr_ctrl;
   logic        memrd_ctrl;
   logic [17:0] mem_addr;
   logic [15:0] wr_data;
   logic        stall;
   logic [15:0] res_out;
   logic        flag_out;
   logic        out_valid;
   logic [17:0] ram_addr;
   logic [15:0] ram_data_out;
   logic        ram_data_oe;
   logic [15:0] ram_data_in;
   logic        ram_ce_n;
   logic        ram_oe_n;
   logic        ram_we_n;

   int check_cnt = 0;
   int pass_cnt  = 0;

   mem_stage_ctrl #(.DATA_W(16), .ADDR_W(18), .WAIT_CYC(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid        (valid),
      .res          (res),
      .flag         (flag),
      .memwr_ctrl   (memwr_ctrl),
      .memrd_ctrl   (memrd_ctrl),
      .mem_addr     (mem_addr),
      .wr_data      (wr_data),
      .stall        (stall),
      .res_out      (res_out),
      .flag_out     (flag_out),
      .out_valid    (out_valid),
      .ram_addr     (ram_addr),
      .ram_data_out (ram_data_out),
      .ram_data_oe  (ram_data_oe),
      .ram_data_in  (ram_data_in),
      .ram_ce_n     (ram_ce_n),
      .ram_oe_n     (ram_oe_n),
      .ram_we_n     (ram_we_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else
         pass_cnt++;
   endtask

   // Bus contention rules, evaluated in every sampled cycle.
   task automatic bus_chk();
      check("oe_vs_data_oe", {31'd0, !(!ram_oe_n && ram_data_oe)}, 32'd1);
      check("we_only_in_wr", {31'd0, (ram_we_n || (!ram_ce_n && ram_data_oe && ram_oe_n))}, 32'd1);
   endtask

   task automatic drive(input logic v, input logic wr, input logic rd, input logic [17:0] a,
                        input logic [15:0] wd, input logic [15:0] r, input logic f);
      valid      = v;
      memwr_ctrl = wr;
      memrd_ctrl = rd;
      mem_addr   = a;
      wr_data    = wd;
      res        = r;
      flag       = f;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 18'h0, 16'h0, 16'h0, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      check({pfx, "_res_out"},   32'(res_out),      32'h0);
      check({pfx, "_flag_out"},  32'(flag_out),     32'h0);
      check({pfx, "_out_valid"}, 32'(out_valid),    32'h0);
      check({pfx, "_ce_n"},      32'(ram_ce_n),     32'h1);
      check({pfx, "_oe_n"},      32'(ram_oe_n),     32'h1);
      check({pfx, "_we_n"},      32'(ram_we_n),     32'h1);
      check({pfx, "_data_oe"},   32'(ram_data_oe),  32'h0);
      check({pfx, "_ram_addr"},  32'(ram_addr),     32'h0);
      check({pfx, "_ram_dout"},  32'(ram_data_out), 32'h0);
   endtask

   initial begin
      rst = 1'b0;
      ram_data_in = 16'h0;
      idle();
      #2;
      chk_reset_outputs("init");
      check("init_stall", 32'(stall), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // ---------------- pass-through ----------------
      drive(1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 16'h1234, 1'b1); #1;
      check("pt_stall", 32'(stall), 32'h0);
      bus_chk();
      @(negedge clk);
      idle(); #1;
      check("pt_res_out", 32'(res_out), 32'h1234);
      check("pt_flag_out", 32'(flag_out), 32'h1);
      check("pt_out_valid", 32'(out_valid), 32'h1);
      check("pt_stall2", 32'(stall), 32'h0);
      @(negedge clk);
      #1;
      check("pt_valid_drop", 32'(out_valid), 32'h0);
      $display("txn pass-through res=0x1234 flag=1");
      @(negedge clk);

      // ---------------- read, WAIT_CYC=2 ----------------
      drive(1'b1, 1'b0, 1'b1, 18'h2ABCD, 16'h0, 16'h0, 1'b0);
      ram_data_in = 16'hBEEF; #1;
      check("rd_c0_stall", 32'(stall), 32'h1);
      check("rd_c0_oe_n", 32'(ram_oe_n), 32'h1);
      bus_chk();
      @(negedge clk); #1;
      check("rd_c1_stall", 32'(stall), 32'h1);
      check("rd_c1_oe_n", 32'(ram_oe_n), 32'h0);
      check("rd_c1_ce_n", 32'(ram_ce_n), 32'h0);
      check("rd_c1_addr", 32'(ram_addr), 32'h2ABCD);
      check("rd_c1_out_valid", 32'(out_valid), 32'h0);
      bus_chk();
      @(negedge clk); #1;
      check("rd_c2_stall", 32'(stall), 32'h0);
      check("rd_c2_oe_n", 32'(ram_oe_n), 32'h0);
      check("rd_c2_out_valid", 32'(out_valid), 32'h0);
      bus_chk();
      @(negedge clk);
      idle(); #1;
      check("rd_c3_out_valid", 32'(out_valid), 32'h1);
      check("rd_c3_res_out", 32'(res_out), 32'hBEEF);
      check("rd_c3_flag_out", 32'(flag_out), 32'h0);
      check("rd_c3_oe_n", 32'(ram_oe_n), 32'h1);
      check("rd_c3_ce_n", 32'(ram_ce_n), 32'h1);
      bus_chk();
      @(negedge clk); #1;
      check("rd_c4_out_valid", 32'(out_valid), 32'h0);
      $display("txn read addr=0x2abcd data=0xbeef");
      @(negedge clk);

      // ---------------- write with both controls high ----------------
      drive(1'b1, 1'b1, 1'b1, 18'h00010, 16'h5A5A, 16'h7777, 1'b1); #1;
      check("wr_c0_stall", 32'(stall), 32'h1);
      bus_chk();
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk); #1;
         check($sformatf("wr_c%0d_we_n", c), 32'(ram_we_n), 32'h0);
         check($sformatf("wr_c%0d_oe_n", c), 32'(ram_oe_n), 32'h1);
         check($sformatf("wr_c%0d_data_oe", c), 32'(ram_data_oe), 32'h1);
         check($sformatf("wr_c%0d_stall", c), 32'(stall), 32'h1);
         check($sformatf("wr_c%0d_dout", c), 32'(ram_data_out), 32'h5A5A);
         check($sformatf("wr_c%0d_addr", c), 32'(ram_addr), 32'h00010);
         bus_chk();
      end
      @(negedge clk); #1;
      check("wr_c3_we_n", 32'(ram_we_n), 32'h1);
      check("wr_c3_ce_n", 32'(ram_ce_n), 32'h0);
      check("wr_c3_data_oe", 32'(ram_data_oe), 32'h1);
      check("wr_c3_dout", 32'(ram_data_out), 32'h5A5A);
      check("wr_c3_oe_n", 32'(ram_oe_n), 32'h1);
      check("wr_c3_stall", 32'(stall), 32'h0);
      check("wr_c3_out_valid", 32'(out_valid), 32'h0);
      bus_chk();
      @(negedge clk);
      idle(); #1;
      check("wr_c4_out_valid", 32'(out_valid), 32'h1);
      check("wr_c4_res_out", 32'(res_out), 32'h7777);
      check("wr_c4_flag_out", 32'(flag_out), 32'h1);
      check("wr_c4_data_oe", 32'(ram_data_oe), 32'h0);
      bus_chk();
      $display("txn write addr=0x00010 data=0x5a5a");

      // ---------------- asynchronous reset mid-cycle ----------------
      #2;
      rst = 1'b0; #1;
      chk_reset_outputs("arst");
      @(negedge clk);
      rst = 1'b1;
      $display("txn async reset while idle");
      @(negedge clk);

      // ---------------- back-to-back read then write ----------------
      drive(1'b1, 1'b0, 1'b1, 18'h00123, 16'h0, 16'h0, 1'b1);
      ram_data_in = 16'h0F0F; #1;
      check("bb_c0_stall", 32'(stall), 32'h1);
      bus_chk();
      @(negedge clk); #1; bus_chk();
      check("bb_c1_oe_n", 32'(ram_oe_n), 32'h0);
      @(negedge clk); #1; bus_chk();
      check("bb_c2_stall", 32'(stall), 32'h0);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 18'h3FFFF, 16'hA5A5, 16'h1111, 1'b0); #1;
      check("bb_c3_out_valid", 32'(out_valid), 32'h1);
      check("bb_c3_res_out", 32'(res_out), 32'h0F0F);
      check("bb_c3_flag_out", 32'(flag_out), 32'h1);
      check("bb_c3_stall", 32'(stall), 32'h1);
      bus_chk();
      @(negedge clk); #1; bus_chk();
      check("bb_c4_we_n", 32'(ram_we_n), 32'h0);
      check("bb_c4_out_valid", 32'(out_valid), 32'h0);
      check("bb_c4_addr", 32'(ram_addr), 32'h3FFFF);
      @(negedge clk); #1; bus_chk();
      check("bb_c5_we_n", 32'(ram_we_n), 32'h0);
      @(negedge clk); #1; bus_chk();
      check("bb_c6_we_n", 32'(ram_we_n), 32'h1);
      check("bb_c6_stall", 32'(stall), 32'h0);
      check("bb_c6_dout", 32'(ram_data_out), 32'hA5A5);
      @(negedge clk);
      idle(); #1; bus_chk();
      check("bb_c7_out_valid", 32'(out_valid), 32'h1);
      check("bb_c7_res_out", 32'(res_out), 32'h1111);
      check("bb_c7_flag_out", 32'(flag_out), 32'h0);
      @(negedge clk); #1;
      check("bb_c8_out_valid", 32'(out_valid), 32'h0);
      $display("txn back-to-back read 0x00123 then write 0x3ffff");
      @(negedge clk);

      // ---------------- reset during RD cycle 1 ----------------
      drive(1'b1, 1'b0, 1'b1, 18'h01234, 16'h0, 16'h0, 1'b0);
      ram_data_in = 16'hDEAD; #1;
      @(negedge clk); #1;
      check("rr_c1_oe_n", 32'(ram_oe_n), 32'h0);
      rst = 1'b0; #1;
      check("rr_ce_n", 32'(ram_ce_n), 32'h1);
      check("rr_oe_n", 32'(ram_oe_n), 32'h1);
      check("rr_we_n", 32'(ram_we_n), 32'h1);
      check("rr_data_oe", 32'(ram_data_oe), 32'h0);
      check("rr_out_valid", 32'(out_valid), 32'h0);
      idle();
      @(negedge clk); #1;
      check("rr_hold_out_valid", 32'(out_valid), 32'h0);
      check("rr_hold_res_out", 32'(res_out), 32'h0);
      rst = 1'b1;
      @(negedge clk); #1;
      check("rr_post_out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 18'h0, 16'h0, 16'hCAFE, 1'b1); #1;
      check("rr_pt_stall", 32'(stall), 32'h0);
      @(negedge clk);
      idle(); #1;
      check("rr_pt_out_valid", 32'(out_valid), 32'h1);
      check("rr_pt_res_out", 32'(res_out), 32'hCAFE);
      check("rr_pt_flag_out", 32'(flag_out), 32'h1);
      bus_chk();
      $display("txn reset mid-read, then pass-through res=0xcafe");
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
